// File: rtl/pipeline_control_unit_if.sv
// Decode-stage instruction fields and ALU flags in; staged control, branch and hazard signals out.
interface pipeline_control_unit_if #(
  parameter int OPCODEWIDTH  = 4,
  parameter int REGADDRWIDTH = 4
);
  logic [OPCODEWIDTH-1:0]  opcodeD;
  logic [REGADDRWIDTH-1:0] rs1D;
  logic [REGADDRWIDTH-1:0] rs2D;
  logic [REGADDRWIDTH-1:0] rdD;
  logic                    NE;
  logic                    ZE;
  logic                    VE;
  logic                    CE;
  logic [2:0]              aluControlE;
  logic                    data2SelE;
  logic                    memWriteM;
  logic                    regWriteW;
  logic                    resultSelW;
  logic [REGADDRWIDTH-1:0] rdW;
  logic                    pcSrcE;
  logic                    stallF;
  logic                    stallD;
  logic                    flushD;
  logic                    flushE;
  logic [3:0]              flagsQ;
  logic                    illegalOp;

  modport master (
    output opcodeD, rs1D, rs2D, rdD, NE, ZE, VE, CE,
    input  aluControlE, data2SelE, memWriteM, regWriteW, resultSelW, rdW,
    input  pcSrcE, stallF, stallD, flushD, flushE, flagsQ, illegalOp
  );

  modport slave (
    input  opcodeD, rs1D, rs2D, rdD, NE, ZE, VE, CE,
    output aluControlE, data2SelE, memWriteM, regWriteW, resultSelW, rdW,
    output pcSrcE, stallF, stallD, flushD, flushE, flagsQ, illegalOp
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// D/E/M/W control path: opcode decode, staged control words, NZVC flags,
// branch resolution in E and load-use / taken-branch stall and flush generation.
module pipeline_control_unit #(
  parameter int OPCODEWIDTH  = 4,
  parameter int REGADDRWIDTH = 4,
  parameter bit BRANCHFLUSH  = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  pipeline_control_unit_if.slave bus
);

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic                    mem_read;
    logic                    result_sel;
    logic                    data2_sel;
    logic                    flag_write;
    logic                    is_branch;
    logic [1:0]              br_cond;
    logic [2:0]              alu_control;
    logic [REGADDRWIDTH-1:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic                    result_sel;
    logic [REGADDRWIDTH-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic                    reg_write;
    logic                    result_sel;
    logic [REGADDRWIDTH-1:0] rd;
  } wb_t;

  localparam ctrl_t NOP_WORD = ctrl_t'(1'b0);
  localparam logic [REGADDRWIDTH-1:0] REG_ZERO = {REGADDRWIDTH{1'b0}};

  logic [3:0] op_low_s;
  logic       illegal_d_s;
  logic       valid_d_s;
  ctrl_t      word_d_s;
  ctrl_t      ctrl_e_r;
  mem_t       ctrl_m_r;
  wb_t        ctrl_w_r;
  logic [3:0] flags_r;
  logic       illegal_r;
  logic       cond_s;
  logic       pc_src_s;
  logic       load_use_s;
  logic       flush_e_s;

  assign op_low_s    = bus.opcodeD[3:0];
  assign illegal_d_s = (bus.opcodeD >> 3'd4) != {OPCODEWIDTH{1'b0}};
  assign valid_d_s   = !illegal_d_s && (op_low_s != 4'h0);

  // Opcode decode; illegal opcodes and NOP both produce the all-zero word.
  always_comb begin
    word_d_s = NOP_WORD;
    if (illegal_d_s) begin
      word_d_s = NOP_WORD;
    end else begin
      case (op_low_s)
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          word_d_s.reg_write   = 1'b1;
          word_d_s.flag_write  = 1'b1;
          word_d_s.alu_control = op_low_s[2:0];
          word_d_s.rd          = bus.rdD;
        end
        4'h8: begin
          word_d_s.flag_write  = 1'b1;
          word_d_s.alu_control = 3'b010;
        end
        4'h9: begin
          word_d_s.reg_write   = 1'b1;
          word_d_s.mem_read    = 1'b1;
          word_d_s.result_sel  = 1'b1;
          word_d_s.data2_sel   = 1'b1;
          word_d_s.alu_control = 3'b001;
          word_d_s.rd          = bus.rdD;
        end
        4'hA: begin
          word_d_s.mem_write   = 1'b1;
          word_d_s.data2_sel   = 1'b1;
          word_d_s.alu_control = 3'b001;
        end
        4'hB: begin
          word_d_s.reg_write   = 1'b1;
          word_d_s.data2_sel   = 1'b1;
          word_d_s.rd          = bus.rdD;
        end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          word_d_s.is_branch   = 1'b1;
          word_d_s.br_cond     = op_low_s[1:0];
        end
        default: word_d_s = NOP_WORD;
      endcase
    end
  end

  // Branch condition against the architectural flags {N,Z,V,C}.
  always_comb begin
    cond_s = 1'b0;
    case (ctrl_e_r.br_cond)
      2'b00:   cond_s = 1'b1;
      2'b01:   cond_s = flags_r[2];
      2'b10:   cond_s = !flags_r[2];
      2'b11:   cond_s = flags_r[3] ^ flags_r[1];
      default: cond_s = 1'b0;
    endcase
  end

  assign pc_src_s = ctrl_e_r.is_branch && cond_s;

  // A load in E whose destination a valid D instruction reads; r0 never conflicts.
  always_comb begin
    load_use_s = 1'b0;
    if (ctrl_e_r.mem_read && (ctrl_e_r.rd != REG_ZERO) && valid_d_s &&
        ((ctrl_e_r.rd == bus.rs1D) || (ctrl_e_r.rd == bus.rs2D))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  assign flush_e_s = pc_src_s || load_use_s;

  // Control word pipeline E -> M -> W; a flush inserts the NOP word into E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e_r <= NOP_WORD;
      ctrl_m_r <= mem_t'(1'b0);
      ctrl_w_r <= wb_t'(1'b0);
    end else begin
      ctrl_e_r <= flush_e_s ? NOP_WORD : word_d_s;
      ctrl_m_r <= '{reg_write: ctrl_e_r.reg_write, mem_write: ctrl_e_r.mem_write,
                    result_sel: ctrl_e_r.result_sel, rd: ctrl_e_r.rd};
      ctrl_w_r <= '{reg_write: ctrl_m_r.reg_write, result_sel: ctrl_m_r.result_sel,
                    rd: ctrl_m_r.rd};
    end
  end

  // Architectural flags and the sticky illegal-opcode indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r   <= 4'b0000;
      illegal_r <= 1'b0;
    end else begin
      if (ctrl_e_r.flag_write) begin
        flags_r <= {bus.NE, bus.ZE, bus.VE, bus.CE};
      end
      if (illegal_d_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  assign bus.aluControlE = ctrl_e_r.alu_control;
  assign bus.data2SelE   = ctrl_e_r.data2_sel;
  assign bus.memWriteM   = ctrl_m_r.mem_write;
  assign bus.regWriteW   = ctrl_w_r.reg_write;
  assign bus.resultSelW  = ctrl_w_r.result_sel;
  assign bus.rdW         = ctrl_w_r.rd;
  assign bus.pcSrcE      = pc_src_s;
  assign bus.stallF      = load_use_s && !pc_src_s;
  assign bus.stallD      = load_use_s && !pc_src_s;
  assign bus.flushD      = pc_src_s && BRANCHFLUSH;
  assign bus.flushE      = flush_e_s;
  assign bus.flagsQ      = flags_r;
  assign bus.illegalOp   = illegal_r;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: default build plus a 6-bit-opcode, delay-slot build.
module tb_pipeline_control_unit;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_control_unit_if #(.OPCODEWIDTH(4), .REGADDRWIDTH(4)) bus ();
  pipeline_control_unit_if #(.OPCODEWIDTH(6), .REGADDRWIDTH(4)) bus6 ();

  pipeline_control_unit #(.OPCODEWIDTH(4), .REGADDRWIDTH(4), .BRANCHFLUSH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  pipeline_control_unit #(.OPCODEWIDTH(6), .REGADDRWIDTH(4), .BRANCHFLUSH(1'b0)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd);
    bus.opcodeD = op;
    bus.rs1D    = rs1;
    bus.rs2D    = rs2;
    bus.rdD     = rd;
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {bus.NE, bus.ZE, bus.VE, bus.CE} = f;
  endtask

  function automatic logic [31:0] outs_main();
    return {11'd0, bus.aluControlE, bus.data2SelE, bus.memWriteM, bus.regWriteW,
            bus.resultSelW, bus.rdW, bus.pcSrcE, bus.stallF, bus.stallD, bus.flushD,
            bus.flushE, bus.flagsQ, bus.illegalOp};
  endfunction

  function automatic logic [31:0] outs_six();
    return {11'd0, bus6.aluControlE, bus6.data2SelE, bus6.memWriteM, bus6.regWriteW,
            bus6.resultSelW, bus6.rdW, bus6.pcSrcE, bus6.stallF, bus6.stallD, bus6.flushD,
            bus6.flushE, bus6.flagsQ, bus6.illegalOp};
  endfunction

  initial begin
    rst_n = 1'b0;
    set_flags(4'b0000);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    bus6.opcodeD = 6'd0;
    bus6.rs1D = 4'd0; bus6.rs2D = 4'd0; bus6.rdD = 4'd0;
    {bus6.NE, bus6.ZE, bus6.VE, bus6.CE} = 4'b0000;

    // 1: reset holds everything low while ADD toggles in D
    for (int i = 0; i < 4; i++) begin
      bus.opcodeD  = (i % 2 == 0) ? 4'h1 : 4'h0;
      bus6.opcodeD = (i % 2 == 0) ? 6'd1 : 6'd0;
      bus.rdD = 4'h5;
      tick();
    end
    check_eq("reset_outs", outs_main(), 32'd0);
    check_eq("reset_outs6", outs_six(), 32'd0);
    bus6.opcodeD = 6'd0;
    rst_n = 1'b1;
    drive(4'h1, 4'h1, 4'h2, 4'h5);
    tick();
    check_eq("add_aluE", {29'd0, bus.aluControlE}, 32'd1);
    check_eq("add_not_yet_w1", {31'd0, bus.regWriteW}, 32'd0);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    check_eq("add_not_yet_w2", {31'd0, bus.regWriteW}, 32'd0);
    tick();
    check_eq("add_regwrite_w", {27'd0, bus.regWriteW, bus.rdW}, {27'd0, 1'b1, 4'h5});

    // 2: CMP sets flags, BEQ taken
    drive(4'h8, 4'h1, 4'h2, 4'h0);
    tick();
    check_eq("cmp_aluE", {29'd0, bus.aluControlE}, 32'd2);
    set_flags(4'b0101);
    drive(4'hD, 4'h0, 4'h0, 4'h0);
    tick();
    check_eq("cmp_flags", {28'd0, bus.flagsQ}, 32'h5);
    set_flags(4'b1111);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    check_eq("beq_taken", {27'd0, bus.pcSrcE, bus.flushD, bus.flushE, bus.stallF, bus.stallD},
             {27'd0, 5'b11100});
    tick();
    check_eq("branch_no_flagwrite", {28'd0, bus.flagsQ}, 32'h5);
    check_eq("flushed_e_nobranch", {31'd0, bus.pcSrcE}, 32'd0);
    check_eq("cmp_no_regwrite_w", {31'd0, bus.regWriteW}, 32'd0);
    tick();
    check_eq("bubble_no_flagwrite", {28'd0, bus.flagsQ}, 32'h5);

    // 3: flags cleared, BNE taken, BEQ and BLT not taken
    set_flags(4'b0000);
    drive(4'h1, 4'h1, 4'h2, 4'h6);
    tick();
    drive(4'hE, 4'h0, 4'h0, 4'h0);
    tick();
    check_eq("add_flags_zero", {28'd0, bus.flagsQ}, 32'h0);
    check_eq("bne_taken", {29'd0, bus.pcSrcE, bus.flushD, bus.flushE}, 32'h7);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    drive(4'hD, 4'h0, 4'h0, 4'h0);
    tick();
    check_eq("beq_not_taken", {29'd0, bus.pcSrcE, bus.flushD, bus.flushE}, 32'h0);
    drive(4'hF, 4'h0, 4'h0, 4'h0);
    tick();
    check_eq("blt_not_taken", {29'd0, bus.pcSrcE, bus.flushD, bus.flushE}, 32'h0);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick();

    // 4: load-use on rs1, then r0 load, then rs2 match
    drive(4'h9, 4'h2, 4'h0, 4'h3);
    tick();
    check_eq("ldr_data2sel", {31'd0, bus.data2SelE}, 32'd1);
    drive(4'h1, 4'h3, 4'h1, 4'h4);
    check_eq("loaduse_rs1", {28'd0, bus.stallF, bus.stallD, bus.flushE, bus.pcSrcE}, 32'hE);
    tick();
    check_eq("loaduse_released", {29'd0, bus.stallF, bus.stallD, bus.flushE}, 32'h0);
    check_eq("loaduse_bubble_e", {29'd0, bus.aluControlE}, 32'd0);
    tick();
    check_eq("consumer_in_e", {29'd0, bus.aluControlE}, 32'd1);
    check_eq("ldr_wb", {26'd0, bus.regWriteW, bus.resultSelW, bus.rdW}, {26'd0, 2'b11, 4'h3});
    drive(4'h9, 4'h2, 4'h0, 4'h0);
    tick();
    drive(4'h1, 4'h0, 4'h1, 4'h4);
    check_eq("loaduse_r0", {29'd0, bus.stallF, bus.stallD, bus.flushE}, 32'h0);
    tick();
    check_eq("r0_consumer_in_e", {29'd0, bus.aluControlE}, 32'd1);
    drive(4'h9, 4'h2, 4'h0, 4'h7);
    tick();
    drive(4'h1, 4'h1, 4'h7, 4'h2);
    check_eq("loaduse_rs2", {29'd0, bus.stallF, bus.stallD, bus.flushE}, 32'h7);
    tick();
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick();

    // 5: taken branch overrides any stall
    drive(4'hC, 4'h0, 4'h0, 4'h3);
    tick();
    drive(4'h1, 4'h3, 4'h3, 4'h4);
    check_eq("branch_priority",
             {27'd0, bus.pcSrcE, bus.flushD, bus.flushE, bus.stallF, bus.stallD}, 32'h1C);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick();

    // 6: illegal opcode on the 6-bit, delay-slot build
    bus6.opcodeD = 6'b010001;
    bus6.rdD = 4'h5;
    {bus6.NE, bus6.ZE, bus6.VE, bus6.CE} = 4'b1111;
    #1;
    check_eq("illegal_before_edge", {31'd0, bus6.illegalOp}, 32'd0);
    tick();
    check_eq("illegal_set", {31'd0, bus6.illegalOp}, 32'd1);
    check_eq("illegal_nop_e", {29'd0, bus6.aluControlE}, 32'd0);
    bus6.opcodeD = 6'd0;
    tick();
    tick();
    check_eq("illegal_no_wb", {27'd0, bus6.regWriteW, bus6.rdW}, 32'd0);
    check_eq("illegal_no_flags", {28'd0, bus6.flagsQ}, 32'd0);
    bus6.opcodeD = 6'h0C;
    tick();
    check_eq("delayslot_branch", {29'd0, bus6.pcSrcE, bus6.flushD, bus6.flushE}, 32'h5);
    bus6.opcodeD = 6'd0;
    tick();
    check_eq("illegal_sticky", {31'd0, bus6.illegalOp}, 32'd1);

    // mid-operation async reset discards in-flight words
    set_flags(4'b1010);
    drive(4'h1, 4'h1, 4'h1, 4'h9);
    tick();
    drive(4'hA, 4'h1, 4'h2, 4'h0);
    tick();
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    check_eq("inflight_state",
             {22'd0, bus.memWriteM, bus.regWriteW, bus.rdW, bus.flagsQ},
             {22'd0, 1'b1, 1'b1, 4'h9, 4'b1010});
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outs", outs_main(), 32'd0);
    check_eq("async_reset_illegal", {31'd0, bus6.illegalOp}, 32'd0);
    tick();
    check_eq("reset_hold_outs", outs_main(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
